// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: credit-limited in-order word requests, a registered
// FIFO of {pc, insn}, and redirect flush. Define FETCH_TRACE_EN for handoff/redirect trace prints.

module pipeline_fetch_checker #(
    parameter int CW         = 2,
    parameter int FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [CW-1:0] count
);

    // A push must always find a free slot; the credit rule is meant to guarantee this.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(FIFO_DEPTH))));

endmodule

module pipeline_fetch #(
    parameter int                           ADDR_WIDTH = 64,
    parameter int                           DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter int                           FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH/2-1:0]      BUBBLE     = 32'd90
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    imem_req_valid,
    output logic [ADDR_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [DATA_WIDTH/2-1:0] imem_resp_data,
    input  logic                    next_stage_ready,
    output logic [DATA_WIDTH/2-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]   instruction_pc
);

    localparam int IW = DATA_WIDTH / 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]         data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [FIFO_DEPTH];

    logic [CW:0]           used_s;
    logic                  credit_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CW-1:0]         live_s;
    logic [ADDR_WIDTH-1:0] resp_pc_s;
    logic [ADDR_WIDTH-1:0] redirect_word_s;

    // Request handshake and FIFO push/pop qualifiers.
    always_comb begin
        used_s          = {1'b0, count_q} + {1'b0, outst_q};
        credit_s        = used_s < (CW+1)'(FIFO_DEPTH);
        imem_req_valid  = reset && credit_s && !redirect_valid;
        imem_req_addr   = fetch_pc_q;
        accept_s        = imem_req_valid && imem_req_ready;
        push_s          = imem_resp_valid && (drop_q == {CW{1'b0}}) && !redirect_valid;
        pop_s           = (count_q != {CW{1'b0}}) && next_stage_ready && !redirect_valid;
        // Live (non-dropped) requests are consecutive words ending just below fetch_pc.
        live_s          = outst_q - drop_q;
        resp_pc_s       = fetch_pc_q - (ADDR_WIDTH'(live_s) << 2);
        redirect_word_s = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    end

    // Next-state for PC, counters and pointers; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(accept_s) - CW'(imem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_word_s;
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            drop_d     = outst_q - CW'(imem_resp_valid);
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_resp_valid && (drop_q != {CW{1'b0}})) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            wr_ptr_d = wr_ptr_q + PW'(push_s);
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= {CW{1'b0}};
            outst_q    <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= {IW{1'b0}};
                pc_q[i]   <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            data_q[wr_ptr_q] <= imem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_s;
        end
    end

    // Head presentation from registered state only.
    always_comb begin
        if (count_q != {CW{1'b0}}) begin
            instruction    = data_q[rd_ptr_q];
            instruction_pc = pc_q[rd_ptr_q];
        end else begin
            instruction    = BUBBLE;
            instruction_pc = {ADDR_WIDTH{1'b0}};
        end
    end

    pipeline_fetch_checker #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_checker (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .count (count_q)
    );

`ifdef FETCH_TRACE_EN
    // Trace of handoffs and redirects.
    always @(posedge clk) begin
        if (reset) begin
            if (redirect_valid) begin
                $display("REDIRECT %h drop=%0d", redirect_word_s, drop_d);
            end else if (pop_s) begin
                $display("FETCH pc=%h insn=%h", instruction_pc, instruction);
            end
        end
    end
`else
    // Trace disabled: no display logic.
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Randomized bench for pipeline_fetch against a queue-based model of in-flight
// requests and the decode buffer, with an in-order memory responder.

module tb_pipeline_fetch;

    localparam int          AW    = 64;
    localparam int          DW    = 64;
    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;
    localparam logic [31:0] BUB   = 32'd90;

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;
    logic          next_stage_ready;
    logic [31:0]   instruction;
    logic [AW-1:0] instruction_pc;

    pipeline_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH),
        .BUBBLE     (BUB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .next_stage_ready (next_stage_ready),
        .instruction      (instruction),
        .instruction_pc   (instruction_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] addr; logic stale; } req_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] insn; } ent_t;
    typedef struct packed { logic [31:0] data; logic [31:0] edge_no; } mem_t;

    req_t infl_q[$];
    ent_t buf_q[$];
    mem_t mem_q[$];

    logic [63:0] exp_pc;
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          p_rdy, p_resp, p_nsr, p_redir;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1234_0013;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_head();
        if (buf_q.size() != 0) begin
            check_value("insn", {32'h0, instruction}, {32'h0, buf_q[0].insn});
            check_value("insn_pc", instruction_pc, buf_q[0].pc);
        end else begin
            check_value("insn_bubble", {32'h0, instruction}, {32'h0, BUB});
            check_value("insn_pc_empty", instruction_pc, 64'h0);
        end
    endtask

    task automatic model_clear();
        infl_q.delete();
        buf_q.delete();
        mem_q.delete();
        exp_pc = RPC;
    endtask

    task automatic run_cycles(input int n);
        logic   exp_valid;
        logic   do_pop;
        req_t   r;
        logic [63:0] rpc;
        for (int i = 0; i < n; i++) begin
            check_head();
            rpc = ($urandom_range(3) == 0) ? {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom())}
                                           : {32'h0, 32'($urandom())};
            redirect_valid   = ($urandom_range(99) < p_redir);
            redirect_pc      = rpc;
            imem_req_ready   = ($urandom_range(99) < p_rdy);
            next_stage_ready = ($urandom_range(99) < p_nsr);
            if (mem_q.size() != 0 && mem_q[0].edge_no < 32'(cyc) && $urandom_range(99) < p_resp) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_q[0].data;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
            #1;
            exp_valid = ((buf_q.size() + infl_q.size()) < DEPTH) && !redirect_valid;
            check_value("req_valid", {63'h0, imem_req_valid}, {63'h0, exp_valid});
            check_value("req_addr", imem_req_addr, exp_pc);
            // memory side follows the DUT's actual handshakes
            if (imem_resp_valid) void'(mem_q.pop_front());
            if (imem_req_valid && imem_req_ready)
                mem_q.push_back({mem_word(imem_req_addr), 32'(cyc)});
            // reference model update for the coming edge
            do_pop = !redirect_valid && buf_q.size() != 0 && next_stage_ready;
            if (do_pop) void'(buf_q.pop_front());
            if (imem_resp_valid && infl_q.size() != 0) begin
                r = infl_q.pop_front();
                if (!r.stale && !redirect_valid) buf_q.push_back({r.addr, mem_word(r.addr)});
            end
            if (redirect_valid) begin
                buf_q.delete();
                foreach (infl_q[k]) infl_q[k].stale = 1'b1;
                exp_pc = {rpc[63:2], 2'b00};
            end else if (exp_valid && imem_req_ready) begin
                infl_q.push_back({exp_pc, 1'b0});
                exp_pc = exp_pc + 64'd4;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input int hold);
        reset            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 64'h0;
        imem_req_ready   = 1'b0;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = 32'h0;
        next_stage_ready = 1'b0;
        #1;
        check_value("rst_insn", {32'h0, instruction}, {32'h0, BUB});
        check_value("rst_insn_pc", instruction_pc, 64'h0);
        check_value("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        model_clear();
        for (int i = 0; i < hold; i++) @(negedge clk);
        check_value("rst_addr", imem_req_addr, RPC);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        cyc = 0;
        @(negedge clk);
        apply_reset(2);

        // streaming: memory always ready, single-cycle responses, decode always ready
        p_rdy = 100; p_resp = 100; p_nsr = 100; p_redir = 0;
        run_cycles(12);
        // decode stalls, then resumes
        p_nsr = 0;
        run_cycles(6);
        p_nsr = 100;
        run_cycles(6);
        // memory refuses requests for a while
        p_rdy = 0;
        run_cycles(4);
        p_rdy = 100;
        run_cycles(4);
        // redirect-heavy random traffic
        p_rdy = 60; p_resp = 60; p_nsr = 70; p_redir = 25;
        run_cycles(300);
        p_redir = 6;
        run_cycles(1500);

        // mid-stream reset
        p_rdy = 100; p_resp = 0; p_nsr = 100; p_redir = 0;
        run_cycles(3);
        apply_reset(2);
        p_resp = 100;
        run_cycles(8);
        p_rdy = 50; p_resp = 50; p_nsr = 50; p_redir = 8;
        run_cycles(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
